// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Fetch-stage direct-mapped branch target buffer for the RV32I pipeline.
// Each entry holds a valid bit, a tag, a taken-target and a 2-bit saturating
// direction counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
//
// The lookup path is combinational and zero latency: it predicts the next
// fetch PC for if_pc from the state as it stood before the current edge.
// The resolution path compares the EX-stage outcome against the prediction
// that travelled down the pipe. It raises a redirect on mismatch and trains
// the table on the following rising edge.
//
// Ports
//   clk              in   1   system clock, rising edge
//   rst_n            in   1   synchronous active-low reset
//   if_pc            in  32   current fetch PC
//   if_pred_taken    out  1   predicted direction for if_pc
//   if_pred_pc       out 32   predicted next fetch PC
//   ex_is_branch     in   1   EX holds a valid conditional branch
//   ex_pc            in  32   PC of that branch
//   ex_taken         in   1   resolved direction
//   ex_target        in  32   resolved taken target
//   ex_pred_taken    in   1   direction predicted at fetch
//   ex_pred_pc       in  32   next PC predicted at fetch
//   ex_mispredict    out  1   flush / redirect request
//   ex_redirect_pc   out 32   correct next PC
//   branch_count     out 32   resolved branches (saturating)
//   mispredict_count out 32   mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 32 - IDX_BITS - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_pc,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_pc,
  output logic        ex_mispredict,
  output logic [31:0] ex_redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Saturating increment of a 2-bit direction counter.
  function automatic logic [1:0] f_ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  // Saturating decrement of a 2-bit direction counter.
  function automatic logic [1:0] f_ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  // Saturating increment of a 32-bit statistics counter.
  function automatic logic [31:0] f_sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : v + 32'd1;
  endfunction

  // Table storage. Only the valid bits are reset; the other fields are
  // always written together with the valid bit during allocation.
  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  // Lookup-side decode of the fetch PC (bits [1:0] are never used for
  // indexing or tagging).
  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0] w_if_tag;
  logic                w_if_hit;
  logic [31:0]         w_if_seq_pc;

  assign w_if_idx    = if_pc[IDX_BITS+1:2];
  assign w_if_tag    = if_pc[31:IDX_BITS+2];
  assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_if_seq_pc = if_pc + 32'd4;

  assign if_pred_taken = w_if_hit && r_ctr[w_if_idx][1];
  assign if_pred_pc    = if_pred_taken ? r_target[w_if_idx] : w_if_seq_pc;

  // Resolution-side decode of the branch PC.
  logic [IDX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0] w_ex_tag;
  logic                w_ex_hit;
  logic                w_upd_hit;
  logic                w_alloc;

  assign w_ex_idx = ex_pc[IDX_BITS+1:2];
  assign w_ex_tag = ex_pc[31:IDX_BITS+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // A hit always trains the counter. A miss allocates only when taken,
  // because a not-taken branch would be predicted correctly by the
  // sequential fall-through anyway.
  assign w_upd_hit = ex_is_branch && w_ex_hit;
  assign w_alloc   = ex_is_branch && !w_ex_hit && ex_taken;

  // A predicted-taken branch whose target moved is also a mispredict, even
  // though the direction matched.
  assign ex_mispredict  = ex_is_branch &&
                          ((ex_taken != ex_pred_taken) ||
                           (ex_taken && (ex_target != ex_pred_pc)));
  assign ex_redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

  // Valid bits: cleared by reset, set on allocation. Reset takes priority
  // over a same-cycle allocation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= {ENTRIES{1'b0}};
    end else if (w_alloc) begin
      r_valid[w_ex_idx] <= 1'b1;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Tag, target and counter fields. Writes are suppressed while reset is
  // asserted so that an in-flight update cannot leave stale content behind.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_alloc) begin
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= ex_target;
        r_ctr[w_ex_idx]    <= 2'b10;
      end else if (w_upd_hit) begin
        if (ex_taken) begin
          r_ctr[w_ex_idx]    <= f_ctr_inc(r_ctr[w_ex_idx]);
          r_target[w_ex_idx] <= ex_target;
        end else begin
          r_ctr[w_ex_idx]    <= f_ctr_dec(r_ctr[w_ex_idx]);
        end
      end
    end
  end

  // Statistics counters. Both counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else begin
      if (ex_is_branch) begin
        r_branch_count <= f_sat_inc32(r_branch_count);
      end else begin
        r_branch_count <= r_branch_count;
      end
      if (ex_mispredict) begin
        r_mispredict_count <= f_sat_inc32(r_mispredict_count);
      end else begin
        r_mispredict_count <= r_mispredict_count;
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_pc;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_pc;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int errors;
  int checks;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_pc       (if_pred_pc),
    .ex_is_branch     (ex_is_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_pc       (ex_pred_pc),
    .ex_mispredict    (ex_mispredict),
    .ex_redirect_pc   (ex_redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_branch(input logic [31:0] pc, input logic tk,
                              input logic [31:0] tgt, input logic ptk,
                              input logic [31:0] ppc);
    ex_is_branch  = 1'b1;
    ex_pc         = pc;
    ex_taken      = tk;
    ex_target     = tgt;
    ex_pred_taken = ptk;
    ex_pred_pc    = ppc;
    #1;
  endtask

  task automatic idle_ex();
    ex_is_branch  = 1'b0;
    ex_pc         = 32'h0;
    ex_taken      = 1'b0;
    ex_target     = 32'h0;
    ex_pred_taken = 1'b0;
    ex_pred_pc    = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_ex();
    if_pc = 32'h100;
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %0h want 0", if_pred_taken); end
    checks++; if (if_pred_pc !== 32'h104) begin errors++; $display("FAIL reset_pred_pc: got %08h want 00000104", if_pred_pc); end
    checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL reset_branch_count: got %0d want 0", branch_count); end
    checks++; if (mispredict_count !== 32'd0) begin errors++; $display("FAIL reset_mispredict_count: got %0d want 0", mispredict_count); end
  endtask

  task automatic test_allocate();
    drive_branch(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    checks++; if (ex_mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict: got %0h want 1", ex_mispredict); end
    checks++; if (ex_redirect_pc !== 32'h40) begin errors++; $display("FAIL alloc_redirect: got %08h want 00000040", ex_redirect_pc); end
    step();
    idle_ex();
    if_pc = 32'h100;
    #1;
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_lookup_taken: got %0h want 1", if_pred_taken); end
    checks++; if (if_pred_pc !== 32'h40) begin errors++; $display("FAIL alloc_lookup_pc: got %08h want 00000040", if_pred_pc); end
    checks++; if (mispredict_count !== 32'd1) begin errors++; $display("FAIL alloc_mispredict_count: got %0d want 1", mispredict_count); end
    checks++; if (branch_count !== 32'd1) begin errors++; $display("FAIL alloc_branch_count: got %0d want 1", branch_count); end
  endtask

  task automatic test_train();
    // Correctly predicted taken twice: ctr 10 -> 11 -> 11.
    for (int i = 0; i < 2; i++) begin
      drive_branch(32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
      checks++; if (ex_mispredict !== 1'b0) begin errors++; $display("FAIL train_correct_%0d: got %0h want 0", i, ex_mispredict); end
      step();
    end
    // Not taken against a taken prediction: ctr 11 -> 10.
    drive_branch(32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    checks++; if (ex_mispredict !== 1'b1) begin errors++; $display("FAIL train_nt_mispredict: got %0h want 1", ex_mispredict); end
    checks++; if (ex_redirect_pc !== 32'h104) begin errors++; $display("FAIL train_nt_redirect: got %08h want 00000104", ex_redirect_pc); end
    step();
    idle_ex();
    if_pc = 32'h100;
    #1;
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL train_still_taken: got %0h want 1", if_pred_taken); end
    checks++; if (if_pred_pc !== 32'h40) begin errors++; $display("FAIL train_still_pc: got %08h want 00000040", if_pred_pc); end
    checks++; if (branch_count !== 32'd4) begin errors++; $display("FAIL train_branch_count: got %0d want 4", branch_count); end
    checks++; if (mispredict_count !== 32'd2) begin errors++; $display("FAIL train_mispredict_count: got %0d want 2", mispredict_count); end
    // One more not-taken: ctr 10 -> 01, which now predicts not taken.
    drive_branch(32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    step();
    idle_ex();
    #1;
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL train_weak_nt: got %0h want 0", if_pred_taken); end
    checks++; if (if_pred_pc !== 32'h104) begin errors++; $display("FAIL train_weak_nt_pc: got %08h want 00000104", if_pred_pc); end
  endtask

  task automatic test_alias();
    // 0x500 shares index 0 with 0x100 and evicts it.
    drive_branch(32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
    step();
    idle_ex();
    if_pc = 32'h100;
    #1;
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_old_taken: got %0h want 0", if_pred_taken); end
    checks++; if (if_pred_pc !== 32'h104) begin errors++; $display("FAIL alias_old_pc: got %08h want 00000104", if_pred_pc); end
    if_pc = 32'h500;
    #1;
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new_taken: got %0h want 1", if_pred_taken); end
    checks++; if (if_pred_pc !== 32'h600) begin errors++; $display("FAIL alias_new_pc: got %08h want 00000600", if_pred_pc); end
    // Miss and not taken: nothing is written at index 2.
    drive_branch(32'h208, 1'b0, 32'h300, 1'b0, 32'h20C);
    checks++; if (ex_mispredict !== 1'b0) begin errors++; $display("FAIL miss_nt_mispredict: got %0h want 0", ex_mispredict); end
    step();
    idle_ex();
    if_pc = 32'h208;
    #1;
    checks++; if (if_pred_pc !== 32'h20C) begin errors++; $display("FAIL miss_nt_no_alloc: got %08h want 0000020c", if_pred_pc); end
    checks++; if (branch_count !== 32'd7) begin errors++; $display("FAIL alias_branch_count: got %0d want 7", branch_count); end
    checks++; if (mispredict_count !== 32'd4) begin errors++; $display("FAIL alias_mispredict_count: got %0d want 4", mispredict_count); end
  endtask

  task automatic test_target_change();
    drive_branch(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    step();
    drive_branch(32'h100, 1'b1, 32'h80, 1'b1, 32'h40);
    checks++; if (ex_mispredict !== 1'b1) begin errors++; $display("FAIL tgt_mispredict: got %0h want 1", ex_mispredict); end
    checks++; if (ex_redirect_pc !== 32'h80) begin errors++; $display("FAIL tgt_redirect: got %08h want 00000080", ex_redirect_pc); end
    step();
    idle_ex();
    if_pc = 32'h100;
    #1;
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL tgt_lookup_taken: got %0h want 1", if_pred_taken); end
    checks++; if (if_pred_pc !== 32'h80) begin errors++; $display("FAIL tgt_lookup_pc: got %08h want 00000080", if_pred_pc); end
    checks++; if (mispredict_count !== 32'd6) begin errors++; $display("FAIL tgt_mispredict_count: got %0d want 6", mispredict_count); end
  endtask

  task automatic test_same_cycle();
    // Lookup and allocation of index 3 in the same cycle: no bypass.
    if_pc = 32'h10C;
    drive_branch(32'h10C, 1'b1, 32'hC0, 1'b0, 32'h110);
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_taken: got %0h want 0", if_pred_taken); end
    checks++; if (if_pred_pc !== 32'h110) begin errors++; $display("FAIL same_cycle_pc: got %08h want 00000110", if_pred_pc); end
    step();
    idle_ex();
    #1;
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL next_cycle_taken: got %0h want 1", if_pred_taken); end
    checks++; if (if_pred_pc !== 32'hC0) begin errors++; $display("FAIL next_cycle_pc: got %08h want 000000c0", if_pred_pc); end
    // Low two PC bits are ignored by the lookup.
    if_pc = 32'h10F;
    #1;
    checks++; if (if_pred_pc !== 32'hC0) begin errors++; $display("FAIL low_bits_ignored: got %08h want 000000c0", if_pred_pc); end
    // No branch in EX: no mispredict even with disagreeing fields.
    ex_is_branch  = 1'b0;
    ex_taken      = 1'b1;
    ex_pred_taken = 1'b0;
    #1;
    checks++; if (ex_mispredict !== 1'b0) begin errors++; $display("FAIL no_branch_mispredict: got %0h want 0", ex_mispredict); end
    idle_ex();
  endtask

  task automatic test_reset_mid_update();
    rst_n = 1'b0;
    drive_branch(32'h110, 1'b1, 32'h200, 1'b0, 32'h114);
    step();
    rst_n = 1'b1;
    idle_ex();
    if_pc = 32'h110;
    #1;
    checks++; if (if_pred_pc !== 32'h114) begin errors++; $display("FAIL rst_mid_no_alloc: got %08h want 00000114", if_pred_pc); end
    checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL rst_mid_branch_count: got %0d want 0", branch_count); end
    checks++; if (mispredict_count !== 32'd0) begin errors++; $display("FAIL rst_mid_mispredict_count: got %0d want 0", mispredict_count); end
    if_pc = 32'h10C;
    #1;
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_mid_cleared: got %0h want 0", if_pred_taken); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    if_pc  = 32'h0;
    idle_ex();
    test_reset();
    test_allocate();
    test_train();
    test_alias();
    test_target_change();
    test_same_cycle();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage direct-mapped branch target buffer with a 2-bit saturating counter per entry, for the RV32I pipeline.
- Each cycle it predicts the next fetch PC.
- It takes the EX-stage branch resolution (the ExeBranch outcome and the computed target), trains the table and raises a redirect on misprediction.
- It also keeps branch and mispredict statistics counters.

Parameters:
- IDX_BITS, 4, log2 of entry count (16 entries); index = PC[IDX_BITS+1:2].
- TAG_BITS, 32-IDX_BITS-2, tag width = PC[31:IDX_BITS+2].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- if_pc  input  32  current fetch PC.
- if_pred_taken  output  1  prediction for if_pc.
- if_pred_pc  output  32  predicted next fetch PC.
- ex_is_branch  input  1  EX holds a valid opcode-1100011 instruction this cycle.
- ex_pc  input  32  PC of that branch.
- ex_taken  input  1  resolved outcome (ExeBranch).
- ex_target  input  32  resolved taken target.
- ex_pred_taken  input  1  prediction carried down the pipe with the branch.
- ex_pred_pc  input  32  predicted next PC carried down the pipe.
- ex_mispredict  output  1  flush/redirect request.
- ex_redirect_pc  output  32  correct next PC.
- branch_count  output  32  resolved branches.
- mispredict_count  output  32  mispredictions.

Behaviour:
- Storage per entry:
  - valid, 1 bit.
  - tag, TAG_BITS.
  - target, 32 bits.
  - ctr, 2 bits: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (rst_n=0 at a rising edge):
  - All valid bits are cleared; tag, target and ctr are don't-care.
  - branch_count = 0, mispredict_count = 0.
  - Combinational outputs follow from the cleared state: if_pred_taken=0 and if_pred_pc=if_pc+4.
  - Reset mid-update wins: no table write occurs that cycle.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==if_pc tag field.
  - if_pred_taken = hit && ctr[idx][1].
  - if_pred_pc = if_pred_taken ? target[idx] : if_pc+4 (32-bit wrap).
- Resolution (combinational):
  - ex_mispredict = ex_is_branch && (ex_taken!=ex_pred_taken || (ex_taken && ex_target!=ex_pred_pc)).
  - ex_redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - ex_mispredict=0 whenever ex_is_branch=0; ex_redirect_pc is don't-care then.
- Update (rising edge, ex_is_branch=1, rst_n=1), index/tag taken from ex_pc:
  - Hit and taken: ctr saturating +1 (11 stays 11); target <= ex_target.
  - Hit and not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss and taken: allocate, overwriting any occupant. valid=1, tag=ex_pc tag, target=ex_target, ctr=10.
  - Miss and not taken: no write.
- Statistics:
  - branch_count += 1 per ex_is_branch cycle.
  - mispredict_count += 1 per ex_mispredict cycle.
  - Both saturate at 32'hFFFF_FFFF.
- Same-cycle lookup and update to the same index:
  - Lookup sees the pre-edge state; there is no bypass.
  - The new state is visible from the next cycle.
- Aliasing: PCs differing only above the tag field cannot alias. PCs with the same index but a different tag evict each other.
- ex_pc/if_pc bits [1:0] are ignored.

Test Plan:
- Reset then if_pc=0x100 -> if_pred_taken=0, if_pred_pc=0x104, both counters 0.
- Branch at 0x100 resolved taken to 0x40 with ex_pred_taken=0 -> ex_mispredict=1, ex_redirect_pc=0x40. Next cycle if_pc=0x100 -> if_pred_taken=1, if_pred_pc=0x40; mispredict_count=1.
- Same branch resolved taken twice more -> ctr=11. Then one not-taken with ex_pred_taken=1 -> ex_mispredict=1, redirect 0x104; a following lookup still predicts taken (ctr=10).
- Taken branch at 0x100, then a taken branch at 0x500 (same index for IDX_BITS=4, different tag) -> 0x100 lookup misses (pred_pc 0x104), 0x500 hits to its own target.
- Taken-predicted branch whose actual target differs (pred 0x40, actual 0x80) -> ex_mispredict=1, redirect 0x80, entry target becomes 0x80.
- ex_is_branch=1 with rst_n=0 on the same edge -> no allocation, counters remain 0. Also, a lookup and update to the same index in one cycle -> the lookup returns the old prediction.
